// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// multicycle_control_fsm : FETCH/DECODE/EXEC/MEM/WB control sequencer with IR,
//                          memory timeout, illegal-instruction trap, retire count
// Rev 1.0
// ============================================================================
module multicycle_control_fsm #(
    parameter int ENABLE_OPIMM = 1,
    parameter int ENABLE_BNE   = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_instr,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic             i_alu_zero,
    input  logic             i_dmem_ready,
    input  logic             i_trap_clear,
    output logic             o_reg_alu_mux,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic [1:0]       o_alu_op,
    output logic             o_reg_write,
    output logic             o_data_reg_mux,
    output logic             o_branch_ctrl,
    output logic             o_pc_write,
    output logic             o_ir_load,
    output logic             o_illegal_instr,
    output logic             o_mem_fault,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_retired_count
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_TRAP   = 3'd5;

    localparam int             c_TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic           c_TMO_EN   = (MEM_TIMEOUT != 0);

    logic [2:0]       r_state;
    logic [31:0]      r_ir;
    logic [c_TW-1:0]  r_tmo;
    logic [CNT_W-1:0] r_retired;
    logic             r_ill;
    logic             r_mf;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_rtype, w_brop, w_opimm;
    logic       w_is_ld, w_is_sd, w_is_add, w_is_sub, w_is_and, w_is_or;
    logic       w_is_addi, w_is_andi, w_is_ori, w_is_beq, w_is_bne;
    logic       w_is_imm_alu, w_use_imm, w_is_branch, w_is_mem, w_legal;
    logic [1:0] w_alu_op;
    logic       w_unused_ir;

    assign w_opc       = r_ir[6:0];
    assign w_f3        = r_ir[14:12];
    assign w_f7        = r_ir[31:25];
    assign w_unused_ir = ^{r_ir[24:15], r_ir[11:7]};

    assign w_rtype   = (w_opc == 7'b0110011);
    assign w_brop    = (w_opc == 7'b1100011);
    assign w_opimm   = (ENABLE_OPIMM != 0) && (w_opc == 7'b0010011);
    assign w_is_ld   = (w_opc == 7'b0000011) && (w_f3 == 3'b011);
    assign w_is_sd   = (w_opc == 7'b0100011) && (w_f3 == 3'b011);
    assign w_is_add  = w_rtype && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
    assign w_is_sub  = w_rtype && (w_f3 == 3'b000) && (w_f7 == 7'b0100000);
    assign w_is_and  = w_rtype && (w_f3 == 3'b111) && (w_f7 == 7'b0000000);
    assign w_is_or   = w_rtype && (w_f3 == 3'b110) && (w_f7 == 7'b0000000);
    assign w_is_addi = w_opimm && (w_f3 == 3'b000);
    assign w_is_andi = w_opimm && (w_f3 == 3'b111);
    assign w_is_ori  = w_opimm && (w_f3 == 3'b110);
    assign w_is_beq  = w_brop && (w_f3 == 3'b000);
    assign w_is_bne  = (ENABLE_BNE != 0) && w_brop && (w_f3 == 3'b001);

    assign w_is_imm_alu = w_is_addi | w_is_andi | w_is_ori;
    assign w_use_imm    = w_is_ld | w_is_sd | w_is_imm_alu;
    assign w_is_branch  = w_is_beq | w_is_bne;
    assign w_is_mem     = w_is_ld | w_is_sd;
    assign w_legal      = w_is_mem | w_is_add | w_is_sub | w_is_and | w_is_or
                        | w_is_imm_alu | w_is_branch;

    always_comb begin
        w_alu_op = 2'd0;
        if (w_is_ld | w_is_sd | w_is_add | w_is_addi)
            w_alu_op = 2'd2;
        else if (w_is_sub | w_is_branch)
            w_alu_op = 2'd3;
        else if (w_is_or | w_is_ori)
            w_alu_op = 2'd1;
    end

    // Every output is a function of r_state/r_ir; the only input paths are the
    // handshake-completion terms (ir_load, branch outcome, store completion).
    always_comb begin
        o_instr_ready  = 1'b0;
        o_ir_load      = 1'b0;
        o_reg_alu_mux  = 1'b0;
        o_mem_read     = 1'b0;
        o_mem_write    = 1'b0;
        o_alu_op       = 2'd0;
        o_reg_write    = 1'b0;
        o_data_reg_mux = 1'b0;
        o_branch_ctrl  = 1'b0;
        o_pc_write     = 1'b0;
        case (r_state)
            c_FETCH: begin
                o_instr_ready = 1'b1;
                o_ir_load     = i_instr_valid;
            end
            c_EXEC: begin
                o_alu_op      = w_alu_op;
                o_reg_alu_mux = w_use_imm;
                o_pc_write    = w_is_branch;
                o_branch_ctrl = (w_is_beq & i_alu_zero) | (w_is_bne & ~i_alu_zero);
            end
            c_MEM: begin
                o_alu_op      = 2'd2;
                o_reg_alu_mux = 1'b1;
                o_mem_read    = w_is_ld;
                o_mem_write   = w_is_sd;
                o_pc_write    = w_is_sd & i_dmem_ready;
            end
            c_WB: begin
                o_alu_op       = w_alu_op;
                o_reg_alu_mux  = w_use_imm;
                o_reg_write    = 1'b1;
                o_pc_write     = 1'b1;
                o_data_reg_mux = w_is_ld;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_FETCH;
            r_ir      <= '0;
            r_tmo     <= '0;
            r_retired <= '0;
            r_ill     <= 1'b0;
            r_mf      <= 1'b0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (i_instr_valid) begin
                        r_ir    <= i_instr;
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    if (w_legal) begin
                        r_state <= c_EXEC;
                    end else begin
                        r_state <= c_TRAP;
                        r_ill   <= 1'b1;
                    end
                end
                c_EXEC: begin
                    if (w_is_mem) begin
                        r_state <= c_MEM;
                        r_tmo   <= '0;
                    end else if (w_is_branch) begin
                        r_state <= c_FETCH;
                    end else begin
                        r_state <= c_WB;
                    end
                end
                c_MEM: begin
                    // A ready arriving on the last allowed cycle still completes.
                    if (i_dmem_ready) begin
                        r_state <= w_is_ld ? c_WB : c_FETCH;
                    end else if (c_TMO_EN && (r_tmo == c_TMO_LAST)) begin
                        r_state <= c_TRAP;
                        r_mf    <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
                end
                c_WB: r_state <= c_FETCH;
                c_TRAP: begin
                    if (i_trap_clear) begin
                        r_state <= c_FETCH;
                        r_ill   <= 1'b0;
                        r_mf    <= 1'b0;
                    end
                end
                default: r_state <= c_FETCH;
            endcase
            if (o_pc_write)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign o_illegal_instr = r_ill;
    assign o_mem_fault     = r_mf;
    assign o_busy          = (r_state != c_FETCH);
    assign o_retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control_fsm : directed bench with an instruction-level output model
// Rev 1.0
// ============================================================================
module tb_multicycle_control_fsm;

    localparam int P_TMO = 4;
    localparam int P_CW  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     i_instr = '0;
    logic            i_instr_valid = 1'b0;
    logic            i_alu_zero = 1'b0;
    logic            i_dmem_ready = 1'b0;
    logic            i_trap_clear = 1'b0;
    logic            o_instr_ready, o_reg_alu_mux, o_mem_read, o_mem_write;
    logic [1:0]      o_alu_op;
    logic            o_reg_write, o_data_reg_mux, o_branch_ctrl, o_pc_write, o_ir_load;
    logic            o_illegal_instr, o_mem_fault, o_busy;
    logic [P_CW-1:0] o_retired_count;

    multicycle_control_fsm #(
        .ENABLE_OPIMM(1), .ENABLE_BNE(0), .MEM_TIMEOUT(P_TMO), .CNT_W(P_CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
        .o_instr_ready(o_instr_ready), .i_alu_zero(i_alu_zero), .i_dmem_ready(i_dmem_ready),
        .i_trap_clear(i_trap_clear), .o_reg_alu_mux(o_reg_alu_mux), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_alu_op(o_alu_op), .o_reg_write(o_reg_write),
        .o_data_reg_mux(o_data_reg_mux), .o_branch_ctrl(o_branch_ctrl), .o_pc_write(o_pc_write),
        .o_ir_load(o_ir_load), .o_illegal_instr(o_illegal_instr), .o_mem_fault(o_mem_fault),
        .o_busy(o_busy), .o_retired_count(o_retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy, irl, ram, mr, mw;
        logic [1:0] op;
        logic       rw, drm, br, pcw, ill, mf, busy;
    } exp_t;

    typedef enum int {K_LD, K_SD, K_ADD, K_SUB, K_AND, K_OR,
                      K_ADDI, K_ANDI, K_ORI, K_BEQ, K_BNE, K_ILL} kind_t;

    exp_t act;
    assign act = {o_instr_ready, o_ir_load, o_reg_alu_mux, o_mem_read, o_mem_write, o_alu_op,
                  o_reg_write, o_data_reg_mux, o_branch_ctrl, o_pc_write,
                  o_illegal_instr, o_mem_fault, o_busy};

    int   tests = 0;
    int   fails = 0;
    int   model_ret = 0;
    logic m_ill = 1'b0;
    logic m_mf  = 1'b0;
    exp_t hist[$];

    function automatic kind_t classify(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (op == 7'b0000011 && f3 == 3'b011) return K_LD;
        if (op == 7'b0100011 && f3 == 3'b011) return K_SD;
        if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return K_ADD;
        if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return K_SUB;
        if (op == 7'b0110011 && f3 == 3'b111 && f7 == 7'b0000000) return K_AND;
        if (op == 7'b0110011 && f3 == 3'b110 && f7 == 7'b0000000) return K_OR;
        if (op == 7'b0010011 && f3 == 3'b000) return K_ADDI;
        if (op == 7'b0010011 && f3 == 3'b111) return K_ANDI;
        if (op == 7'b0010011 && f3 == 3'b110) return K_ORI;
        if (op == 7'b1100011 && f3 == 3'b000) return K_BEQ;
        return K_ILL;  // BNE is disabled in this build
    endfunction

    function automatic logic [1:0] op_of(input kind_t k);
        case (k)
            K_LD, K_SD, K_ADD, K_ADDI: return 2'd2;
            K_SUB, K_BEQ, K_BNE:       return 2'd3;
            K_OR, K_ORI:               return 2'd1;
            default:                   return 2'd0;
        endcase
    endfunction

    function automatic logic imm_of(input kind_t k);
        return (k == K_LD || k == K_SD || k == K_ADDI || k == K_ANDI || k == K_ORI);
    endfunction

    function automatic exp_t busy_base();
        exp_t e;
        e = '0;
        e.ill = m_ill;
        e.mf = m_mf;
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, a, x);
        end
    endtask

    // One clock: drive inputs, compare at negedge against the model, then advance.
    task automatic step(input exp_t e, input logic v, input logic z, input logic dr, input logic tc);
        i_instr_valid = v;
        i_alu_zero = z;
        i_dmem_ready = dr;
        i_trap_clear = tc;
        @(negedge clk);
        hist.push_back(act);
        check("outputs", 32'(act), 32'(e));
        check("retired_count", 32'(o_retired_count), model_ret & ((1 << P_CW) - 1));
        @(posedge clk);
        #1;
        if (e.pcw) model_ret++;
    endtask

    task automatic idle(input logic tc);
        exp_t e;
        e = '0;
        e.rdy = 1'b1;
        e.ill = m_ill;
        e.mf = m_mf;
        step(e, 1'b0, 1'b0, 1'b0, tc);
    endtask

    task automatic trap(input int hold);
        for (int h = 0; h < hold; h++) step(busy_base(), 1'b1, 1'b0, 1'b0, 1'b0);
        step(busy_base(), 1'b1, 1'b0, 1'b0, 1'b1);
        m_ill = 1'b0;
        m_mf = 1'b0;
    endtask

    // nwait = MEM cycles without ready before ready arrives (large = never).
    task automatic run(input logic [31:0] ins, input int nwait, input logic z, input int hold);
        kind_t k;
        exp_t  e;
        logic  dr;
        k = classify(ins);
        hist.delete();
        i_instr = ins;
        e = '0;
        e.rdy = 1'b1;
        e.irl = 1'b1;
        e.ill = m_ill;
        e.mf = m_mf;
        step(e, 1'b1, 1'b0, 1'b0, 1'b0);
        step(busy_base(), 1'b1, 1'b0, 1'b0, 1'b0);
        if (k == K_ILL) begin
            m_ill = 1'b1;
            trap(hold);
            return;
        end
        e = busy_base();
        e.op = op_of(k);
        e.ram = imm_of(k);
        if (k == K_BEQ || k == K_BNE) begin
            e.pcw = 1'b1;
            e.br = (k == K_BEQ) ? z : ~z;
            step(e, 1'b0, z, 1'b0, 1'b0);
            return;
        end
        step(e, 1'b0, z, 1'b0, 1'b0);
        if (k == K_LD || k == K_SD) begin
            for (int j = 0; j < 64; j++) begin
                dr = (j == nwait);
                e = busy_base();
                e.op = 2'd2;
                e.ram = 1'b1;
                e.mr = (k == K_LD);
                e.mw = (k == K_SD);
                e.pcw = (k == K_SD) && dr;
                step(e, 1'b0, 1'b0, dr, 1'b0);
                if (dr) break;
                if (P_TMO != 0 && j + 1 == P_TMO) begin
                    m_mf = 1'b1;
                    trap(hold);
                    return;
                end
            end
            if (k == K_SD) return;
        end
        e = busy_base();
        e.op = op_of(k);
        e.ram = imm_of(k);
        e.rw = 1'b1;
        e.pcw = 1'b1;
        e.drm = (k == K_LD);
        step(e, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = act;
        e.rdy = 1'b0;
        check("reset_outputs", 32'(e), 32'h0);
        check("reset_retired", 32'(o_retired_count), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b1);

        // ADD x3,x1,x2: writeback three cycles after ir_load
        run(32'h002081B3, 0, 1'b0, 0);
        check("add_irload_c0", 32'(hist[0].irl), 32'd1);
        check("add_c3_rw_pcw", {30'd0, hist[3].rw, hist[3].pcw}, 32'd3);
        check("add_c3_aluop", 32'(hist[3].op), 32'd2);
        check("add_c3_drm", 32'(hist[3].drm), 32'd0);
        check("add_retired", 32'(o_retired_count), 32'd1);

        for (int i = 0; i < 16; i++) run(32'h002081B3, 0, 1'b0, 0);
        check("retired_wrap", 32'(o_retired_count), 32'd1);

        // LD interrupted by asynchronous reset in MEM
        hist.delete();
        i_instr = 32'h0000B103;
        e = '0; e.rdy = 1'b1; e.irl = 1'b1;
        step(e, 1'b1, 1'b0, 1'b0, 1'b0);
        step(busy_base(), 1'b0, 1'b0, 1'b0, 1'b0);
        e = busy_base(); e.op = 2'd2; e.ram = 1'b1;
        step(e, 1'b0, 1'b0, 1'b0, 1'b0);
        e.mr = 1'b1;
        step(e, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_memread", 32'(o_mem_read), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_aluop_mux", {29'd0, o_alu_op, o_reg_alu_mux}, 32'd0);
        check("async_rst_retired", 32'(o_retired_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_ret = 0;
        idle(1'b0);

        run(32'h402081B3, 0, 1'b0, 0);  // SUB
        run(32'h0020F1B3, 0, 1'b0, 0);  // AND
        run(32'h0020E1B3, 0, 1'b0, 0);  // OR
        run(32'h00508193, 0, 1'b0, 0);  // ADDI
        run(32'h0050F193, 0, 1'b0, 0);  // ANDI
        run(32'h0050E193, 0, 1'b0, 0);  // ORI

        // LD, ready arrives on the final allowed MEM cycle
        run(32'h0000B103, 3, 1'b0, 0);
        n = 0;
        foreach (hist[i]) if (hist[i].mr) n++;
        check("ld_memread_cycles", n, 4);
        check("ld_wb_rw_drm", {30'd0, hist[hist.size()-1].rw, hist[hist.size()-1].drm}, 32'd3);

        run(32'h0020B023, 1, 1'b0, 0);  // SD, one wait
        idle(1'b1);

        run(32'h00208463, 0, 1'b1, 0);  // BEQ taken
        check("beq_taken_br", {30'd0, hist[2].br, hist[2].pcw}, 32'd3);
        check("beq_aluop", 32'(hist[2].op), 32'd3);
        run(32'h00208463, 0, 1'b0, 0);  // BEQ not taken
        check("beq_nt_br", {30'd0, hist[2].br, hist[2].pcw}, 32'd1);

        // SD timeout
        run(32'h0020B023, 1000, 1'b0, 2);
        n = 0;
        foreach (hist[i]) if (hist[i].mw) n++;
        check("sd_memwrite_cycles", n, 4);
        check("sd_trap_fault_busy", {30'd0, hist[7].mf, hist[7].busy}, 32'd3);
        check("sd_trap_cleared", {29'd0, o_mem_fault, o_illegal_instr, o_busy}, 32'd0);

        run(32'h0000007F, 0, 1'b0, 2);  // bad opcode
        check("ill_flag_after_decode", 32'(hist[2].ill), 32'd1);
        run(32'h022081B3, 0, 1'b0, 1);  // SUB with bad funct7
        run(32'h00209463, 0, 1'b0, 1);  // BNE disabled
        check("bne_disabled_trap", 32'(hist[2].ill), 32'd1);

        run(32'h002081B3, 0, 1'b0, 0);
        idle(1'b0);
        check("final_retired", 32'(o_retired_count), 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
